byte_feeder: RTL and testbench

Upstream stage of the XOR encryption datapath: streams a contiguous block of plaintext bytes from a synchronous-read byte memory into the encrypter. It supplies the data byte, a valid strobe and a last-byte flag. A 2-entry skid buffer lets it absorb downstream backpressure while hiding the 1-cycle memory read latency, and it sustains 1 byte/cycle when the consumer is always ready.

---
 rtl/byte_feeder_pkg.sv | 16 +
 rtl/byte_feeder_if.sv | 32 +++
 rtl/byte_feeder_skid_fifo.sv | 51 +++++
 rtl/byte_feeder.sv | 117 +++++++++++
 tb/tb_byte_feeder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_feeder_pkg.sv
// Shared definitions for the byte feeder: byte width, skid FIFO entry width
// (byte plus last-byte tag) and the feeder FSM state encoding.
package byte_feeder_pkg;

  localparam int unsigned BYTE_W = 8;
  // FIFO entry layout: {data[BYTE_W-1:0], last}
  localparam int unsigned FIFO_W = BYTE_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } feeder_state_e;

endpackage

// File: rtl/byte_feeder_if.sv
// Bundles the byte feeder's control, memory-read and output stream signals.
//   master : the feeder (drives read strobe/address, byte stream, busy/done)
//   slave  : the environment (drives start/params, read data, dout_ready)
interface byte_feeder_if #(
  parameter int unsigned ADDR_W = 10
) ();
  import byte_feeder_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic [BYTE_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              last_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, length, mem_rdata, dout_ready,
    output mem_rd_en, mem_addr, dout, dout_valid, last_data, busy, done
  );

  modport slave (
    output start, base_addr, length, mem_rdata, dout_ready,
    input  mem_rd_en, mem_addr, dout, dout_valid, last_data, busy, done
  );

endinterface

// File: rtl/byte_feeder_skid_fifo.sv
// Two-entry skid FIFO holding {byte, last tag}. The head entry is always
// visible on data_o; count_o reports occupancy (0..2).
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write an entry (caller guarantees a free slot or a pop)
//   pop_i         : remove the head entry (caller guarantees non-empty)
//   data_o        : head entry
//   count_o       : number of entries held
module byte_feeder_skid_fifo
  import byte_feeder_pkg::*;
#(
  parameter int unsigned Width = FIFO_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // Push into a full FIFO is only legal alongside a pop; the write lands in
      // the slot being vacated this cycle.
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/byte_feeder.sv
// Streams a block of bytes from a synchronous-read byte memory to a consumer.
// Reads are issued only while fewer than two bytes are outstanding (in flight
// or buffered), so the two-entry skid FIFO can never overflow yet the stream
// still runs at one byte per cycle when the consumer is always ready.
//   clk           : clock
//   start_reset_n : async active-low reset, aborts any block in progress
//   bus           : start/params, memory read port, byte stream, busy/done
module byte_feeder
  import byte_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input logic          clk,
  input logic          start_reset_n,
  byte_feeder_if.master bus
);

  feeder_state_e     state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_cnt_q;
  logic [1:0]        out_q;
  logic [1:0]        out_d;
  logic              busy_q;
  logic              done_q;
  logic              pend_valid_q;  // a read issued last cycle returns data now
  logic              pend_last_q;

  logic [FIFO_W-1:0] fifo_data;
  logic [1:0]        fifo_count;
  logic              dout_valid;
  logic              pop;
  logic              issue;
  logic              rd_last;

  assign dout_valid = (fifo_count != 2'd0);
  assign pop        = dout_valid && bus.dout_ready;
  // Issue is decided in the same cycle it is driven; counting this cycle's pop
  // is what lets two slots sustain full throughput.
  assign issue      = (state_q == StFetch) && ((out_q != 2'd2) || pop);
  assign rd_last    = (rd_cnt_q == len_q - ADDR_W'(1));
  assign out_d      = out_q + 2'(issue) - 2'(pop);

  always_ff @(posedge clk or negedge start_reset_n) begin
    if (!start_reset_n) begin
      state_q      <= StIdle;
      len_q        <= '0;
      addr_q       <= '0;
      rd_cnt_q     <= '0;
      out_q        <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      pend_valid_q <= issue;
      pend_last_q  <= issue && rd_last;
      out_q        <= out_d;
      if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            addr_q   <= bus.base_addr;
            len_q    <= bus.length;
            rd_cnt_q <= '0;
            if (bus.length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
              busy_q  <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (issue && rd_last) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && fifo_data[0]) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  byte_feeder_skid_fifo #(
    .Width (FIFO_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (start_reset_n),
    .push_i  (pend_valid_q),
    .data_i  ({bus.mem_rdata, pend_last_q}),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign bus.mem_rd_en  = issue;
  assign bus.mem_addr   = addr_q;
  assign bus.dout       = fifo_data[FIFO_W-1:1];
  assign bus.dout_valid = dout_valid;
  assign bus.last_data  = dout_valid && fifo_data[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_byte_feeder.sv
module tb_byte_feeder;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic start_reset_n = 1'b0;

  byte_feeder_if #(.ADDR_W(AW)) bus ();

  byte_feeder #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .start_reset_n (start_reset_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read byte memory
  logic [7:0] mem [1024];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  typedef struct {
    logic [7:0] b;
    logic       l;
    int         c;  // expected presentation cycle, -1 = untimed
  } exp_t;

  exp_t          q_data[$];
  logic [AW-1:0] q_addr[$];
  int            q_done[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  int            iss = 0;
  int            acc = 0;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic          prev_l = 1'b0;
  logic [7:0]    prev_d = 8'h00;
  logic          mon_pop;
  exp_t          mon_e;
  logic [AW-1:0] mon_a;
  int            mon_dc;

  always @(negedge clk) begin
    if (!start_reset_n) begin
      prev_v = 1'b0;
      iss    = 0;
      acc    = 0;
    end else begin
      mon_pop = bus.dout_valid && bus.dout_ready;
      chk("last_without_valid", !(bus.last_data && !bus.dout_valid), bus.last_data, 0);
      if (prev_v && !prev_r) begin
        chk("stall_valid", bus.dout_valid == 1'b1, bus.dout_valid, 1);
        chk("stall_dout", bus.dout == prev_d, bus.dout, prev_d);
        chk("stall_last", bus.last_data == prev_l, bus.last_data, prev_l);
      end
      if (bus.mem_rd_en) begin
        if (q_addr.size() == 0) chk("unexpected_read", 1'b0, bus.mem_addr, 0);
        else begin
          mon_a = q_addr.pop_front();
          chk("mem_addr", bus.mem_addr == mon_a, bus.mem_addr, mon_a);
        end
        chk("outstanding", (iss + 1 - acc - int'(mon_pop)) <= 2,
            iss + 1 - acc - int'(mon_pop), 2);
        iss++;
      end
      if (mon_pop) begin
        if (q_data.size() == 0) chk("unexpected_byte", 1'b0, bus.dout, 0);
        else begin
          mon_e = q_data.pop_front();
          chk("dout", bus.dout == mon_e.b, bus.dout, mon_e.b);
          chk("last_data", bus.last_data == mon_e.l, bus.last_data, mon_e.l);
          if (mon_e.c >= 0) chk("byte_cycle", cyc == mon_e.c, cyc, mon_e.c);
        end
        acc++;
      end
      if (bus.done) begin
        chk("busy_at_done", bus.busy == 1'b0, bus.busy, 0);
        if (q_done.size() == 0) chk("unexpected_done", 1'b0, cyc, 0);
        else begin
          mon_dc = q_done.pop_front();
          if (mon_dc >= 0) chk("done_cycle", cyc == mon_dc, cyc, mon_dc);
        end
      end
      prev_v = bus.dout_valid;
      prev_r = bus.dout_ready;
      prev_d = bus.dout;
      prev_l = bus.last_data;
    end
  end

  // Pulse start for one cycle; t is the cycle in which start is sampled.
  task automatic start_blk(input logic [AW-1:0] base, input logic [AW-1:0] len, output int t);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
    t             = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic push_block(input logic [AW-1:0] base, input int len, input int t);
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k);
      q_addr.push_back(a);
      q_data.push_back('{b: mem[a], l: (k == len - 1), c: (t >= 0) ? t + 3 + k : -1});
    end
    q_done.push_back((t >= 0) ? t + 3 + len : -1);
  endtask

  task automatic wait_done(input bit use_pat, input logic [31:0] pat);
    for (int i = 0; i < 300; i++) begin
      if (q_data.size() == 0 && q_addr.size() == 0 && q_done.size() == 0) break;
      @(posedge clk);
      #1;
      bus.dout_ready = use_pat ? pat[i % 32] : 1'b1;
    end
    chk("block_complete", q_data.size() == 0 && q_addr.size() == 0 && q_done.size() == 0,
        q_data.size() + q_addr.size() + q_done.size(), 0);
    bus.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  int         t;
  logic [7:0] t1_bytes [4];
  logic [AW-1:0] t3_addrs [4];

  initial begin
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.length     = '0;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[16] = 8'hA1; mem[17] = 8'hA2; mem[18] = 8'hA3; mem[19] = 8'hA4;

    // Reset values
    #12;
    chk("rst_mem_rd_en", bus.mem_rd_en == 1'b0, bus.mem_rd_en, 0);
    chk("rst_mem_addr", bus.mem_addr == '0, bus.mem_addr, 0);
    chk("rst_dout", bus.dout == 8'h00, bus.dout, 0);
    chk("rst_dout_valid", bus.dout_valid == 1'b0, bus.dout_valid, 0);
    chk("rst_last", bus.last_data == 1'b0, bus.last_data, 0);
    chk("rst_busy", bus.busy == 1'b0, bus.busy, 0);
    chk("rst_done", bus.done == 1'b0, bus.done, 0);
    start_reset_n = 1'b1;

    // Basic 4-byte block with exact timing
    t1_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    start_blk(10'h010, 10'd4, t);
    for (int k = 0; k < 4; k++) begin
      q_addr.push_back(10'h010 + AW'(k));
      q_data.push_back('{b: t1_bytes[k], l: (k == 3), c: t + 3 + k});
    end
    q_done.push_back(t + 7);
    chk("busy_after_start", bus.busy == 1'b1, bus.busy, 1);
    wait_done(1'b0, 32'h0);

    // Empty block
    start_blk(10'h123, 10'd0, t);
    q_done.push_back(t + 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_len0", bus.busy == 1'b0, bus.busy, 0);
    end
    wait_done(1'b0, 32'h0);

    // Address wrap
    t3_addrs = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    start_blk(10'h3FE, 10'd4, t);
    for (int k = 0; k < 4; k++) begin
      q_addr.push_back(t3_addrs[k]);
      q_data.push_back('{b: mem[t3_addrs[k]], l: (k == 3), c: t + 3 + k});
    end
    q_done.push_back(t + 7);
    wait_done(1'b0, 32'h0);

    // Backpressure, including a run of five low cycles
    start_blk(10'h080, 10'd8, t);
    push_block(10'h080, 8, -1);
    wait_done(1'b1, 32'b1100_0001_1010_0000_1101_1011_0011_1010);

    // Abort mid-block with reset, then a fresh 2-byte block
    start_blk(10'h040, 10'd6, t);
    push_block(10'h040, 6, -1);
    while (cyc < t + 5) begin
      @(posedge clk);
      #1;
    end
    #2;
    start_reset_n = 1'b0;
    #1;
    chk("abort_mem_rd_en", bus.mem_rd_en == 1'b0, bus.mem_rd_en, 0);
    chk("abort_mem_addr", bus.mem_addr == '0, bus.mem_addr, 0);
    chk("abort_dout", bus.dout == 8'h00, bus.dout, 0);
    chk("abort_dout_valid", bus.dout_valid == 1'b0, bus.dout_valid, 0);
    chk("abort_last", bus.last_data == 1'b0, bus.last_data, 0);
    chk("abort_busy", bus.busy == 1'b0, bus.busy, 0);
    chk("abort_done", bus.done == 1'b0, bus.done, 0);
    q_data.delete();
    q_addr.delete();
    q_done.delete();
    repeat (2) @(posedge clk);
    #2;
    start_reset_n = 1'b1;
    start_blk(10'h2F0, 10'd2, t);
    push_block(10'h2F0, 2, t);
    wait_done(1'b0, 32'h0);

    // Start while busy is ignored
    start_blk(10'h100, 10'd5, t);
    push_block(10'h100, 5, t);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = 10'h200;
    bus.length    = 10'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
